// File: rtl/multi_timer.sv
// Multi-channel timer: per-channel one-shot/periodic counters with pause, clear and runtime period load.
// Optional sticky end-of-count interrupt enabled by defining MULTI_TIMER_IRQ_EN.
module multi_timer #(
    parameter int p_channels = 4,
    parameter int p_width    = 8,
    parameter int p_default  = 5
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [p_channels-1:0]         i_start,
    input  logic [p_channels-1:0]         i_stop,
    input  logic [p_channels-1:0]         i_clear,
    input  logic [p_channels-1:0]         i_mode,
    input  logic                          i_load,
    input  logic [((p_channels > 1) ? $clog2(p_channels) : 1)-1:0] i_sel,
    input  logic [p_width-1:0]            i_period,
    input  logic [p_channels-1:0]         i_irq_clr,
    output logic [p_channels*p_width-1:0] o_time,
    output logic [p_channels-1:0]         o_end,
    output logic [p_channels-1:0]         o_busy,
    output logic                          o_irq
);
    localparam int sel_w = (p_channels > 1) ? $clog2(p_channels) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD, ST_END} state_t;

    genvar gi;
    generate
        for (gi = 0; gi < p_channels; gi++) begin : g_chan
            state_t             state_reg, state_next;
            logic [p_width-1:0] count_reg, count_next;
            logic [p_width-1:0] period_reg;
            logic               load_hit;

            // An out-of-range i_sel matches no channel, so such writes vanish.
            assign load_hit = i_load && (i_sel == sel_w'(gi));

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    state_reg  <= ST_IDLE;
                    count_reg  <= '0;
                    period_reg <= p_width'(p_default);
                end else begin
                    state_reg <= state_next;
                    count_reg <= count_next;
                    if (load_hit)
                        period_reg <= i_period;
                end
            end

            always_comb begin
                state_next = state_reg;
                count_next = count_reg;
                if (i_clear[gi]) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                end else if (i_start[gi]) begin
                    state_next = ST_RUN;
                    count_next = '0;
                end else begin
                    unique case (state_reg)
                        ST_IDLE: ;
                        ST_RUN: begin
                            if (i_stop[gi]) begin
                                state_next = ST_HOLD;
                            end else if (count_reg >= period_reg) begin
                                // >= so a period shrunk below the count ends at once.
                                state_next = ST_END;
                                count_next = '0;
                            end else begin
                                count_next = count_reg + 1'b1;
                            end
                        end
                        ST_HOLD: begin
                            if (!i_stop[gi])
                                state_next = ST_RUN;
                        end
                        ST_END: begin
                            state_next = i_mode[gi] ? ST_RUN : ST_IDLE;
                            count_next = '0;
                        end
                    endcase
                end
            end

            assign o_time[gi*p_width +: p_width] = count_reg;
            assign o_end[gi]  = (state_reg == ST_END) && !i_clear[gi];
            assign o_busy[gi] = (state_reg != ST_IDLE);
        end
    endgenerate

`ifdef MULTI_TIMER_IRQ_EN
    logic [p_channels-1:0] flag_reg;

    // A fresh end pulse wins over a coincident clear.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            flag_reg <= '0;
        else
            flag_reg <= o_end | (flag_reg & ~i_irq_clr);
    end

    assign o_irq = |flag_reg;
`else
    logic unused_irq_clr;
    assign unused_irq_clr = ^i_irq_clr;
    assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed scenarios with literal pins plus
// randomized traffic compared every cycle against a behavioural channel model.
module tb_multi_timer;
    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int DEF = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [NCH-1:0]  start, stop, clear, mode, irq_clr;
    logic            load;
    logic [1:0]      sel;
    logic [W-1:0]    period;
    logic [NCH*W-1:0] o_time;
    logic [NCH-1:0]  o_end, o_busy;
    logic            o_irq;

    always #5 clk = ~clk;

    multi_timer #(.p_channels(NCH), .p_width(W), .p_default(DEF)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
        .i_clear(clear), .i_mode(mode), .i_load(load), .i_sel(sel),
        .i_period(period), .i_irq_clr(irq_clr), .o_time(o_time),
        .o_end(o_end), .o_busy(o_busy), .o_irq(o_irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each channel is "active" (counting or paused) or "ending" or neither.
    bit model_valid = 0;
    bit m_active[NCH];
    bit m_paused[NCH];
    bit m_ending[NCH];
    int m_cnt[NCH];
    int m_per[NCH];
    bit m_flag[NCH];

    initial forever begin
        @(posedge clk);
        if (rst) begin
            model_valid = 1;
            for (int k = 0; k < NCH; k++) begin
                m_active[k] = 0; m_paused[k] = 0; m_ending[k] = 0;
                m_cnt[k] = 0; m_per[k] = DEF; m_flag[k] = 0;
            end
        end else if (model_valid) begin
            int new_per[NCH];
            for (int k = 0; k < NCH; k++) new_per[k] = m_per[k];
            if (load && int'(sel) < NCH) new_per[sel] = int'(period);
            for (int k = 0; k < NCH; k++) begin
                bit pulse;
                pulse = m_ending[k] && !clear[k];
                if (pulse) m_flag[k] = 1;
                else if (irq_clr[k]) m_flag[k] = 0;
                if (clear[k]) begin
                    m_active[k] = 0; m_paused[k] = 0; m_ending[k] = 0; m_cnt[k] = 0;
                end else if (start[k]) begin
                    m_active[k] = 1; m_paused[k] = 0; m_ending[k] = 0; m_cnt[k] = 0;
                end else if (m_ending[k]) begin
                    m_ending[k] = 0; m_active[k] = mode[k]; m_cnt[k] = 0;
                end else if (m_active[k] && m_paused[k]) begin
                    m_paused[k] = stop[k];
                end else if (m_active[k]) begin
                    if (stop[k]) m_paused[k] = 1;
                    else if (m_cnt[k] >= m_per[k]) begin
                        m_active[k] = 0; m_ending[k] = 1; m_cnt[k] = 0;
                    end else m_cnt[k] = m_cnt[k] + 1;
                end
            end
            for (int k = 0; k < NCH; k++) m_per[k] = new_per[k];
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial forever begin
        @(negedge clk);
        if (model_valid) begin
            logic [NCH*W-1:0] e_time;
            logic [NCH-1:0]   e_end, e_busy;
            logic             e_irq;
            e_irq = 0;
            for (int k = 0; k < NCH; k++) begin
                e_time[k*W +: W] = W'(m_cnt[k]);
                e_end[k]  = m_ending[k] && !clear[k];
                e_busy[k] = m_active[k] || m_ending[k];
`ifdef MULTI_TIMER_IRQ_EN
                e_irq = e_irq | m_flag[k];
`endif
            end
            chk("model_time", o_time, e_time);
            chk("model_end", o_end, e_end);
            chk("model_busy", o_busy, e_busy);
            chk("model_irq", o_irq, e_irq);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; start = '0; stop = '0; clear = '0; mode = '0; irq_clr = '0;
        load = 0; sel = '0; period = '0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_time", o_time, 0);
        chk("reset_busy", o_busy, 0);
        chk("reset_end", o_end, 0);
        chk("reset_irq", o_irq, 0);

        // One-shot ch0 with the default period: counts 0..5, end on cycle 7.
        tick(); start[0] = 1; tick(); start[0] = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("t1_time0", o_time[0 +: W], (c <= 6) ? c - 1 : 0);
            chk("t1_end0", o_end[0], c == 7);
            chk("t1_busy0", o_busy[0], c <= 7);
            tick();
        end
`ifndef MULTI_TIMER_IRQ_EN
        chk("irq_tied_low", o_irq, 0);
`endif

        // Periodic ch2, period 3: end every 5 cycles.
        mode[2] = 1; load = 1; sel = 2; period = 3; tick(); load = 0;
        start[2] = 1; tick(); start[2] = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 5 || c == 10 || c == 15) chk("t2_end2", o_end[2], 1);
            if (c == 6) chk("t2_end2_low", o_end[2], 0);
            chk("t2_time0", o_time[0 +: W], 0);
            tick();
        end
        clear[2] = 1; mode[2] = 0; tick(); clear[2] = 0;

        // Ch1 paused at count 2 for four cycles.
        start[1] = 1; tick(); start[1] = 0;
        tick(); tick();
        stop[1] = 1;
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk);
            if (c >= 4) chk("t3_hold1", o_time[W +: W], 2);
            tick();
        end
        stop[1] = 0;
        repeat (12) tick();

        // Ch0: clear+start together at count 4, then a lone restart at count 3.
        start[0] = 1; tick(); start[0] = 0;
        repeat (4) tick();
        clear[0] = 1; start[0] = 1; tick(); clear[0] = 0; start[0] = 0;
        @(negedge clk);
        chk("t4_clr_time0", o_time[0 +: W], 0);
        chk("t4_clr_busy0", o_busy[0], 0);
        start[0] = 1; tick(); start[0] = 0;
        repeat (3) tick();
        start[0] = 1; tick(); start[0] = 0;
        @(negedge clk);
        chk("t4_rst_time0", o_time[0 +: W], 0);
        chk("t4_rst_busy0", o_busy[0], 1);
        tick();
        @(negedge clk);
        chk("t4_rst_time0b", o_time[0 +: W], 1);
        clear[0] = 1; tick(); clear[0] = 0;

        // Ch3 period 10 shrunk to 2 at count 7: ends after the next RUN cycle.
        load = 1; sel = 3; period = 10; tick(); load = 0;
        start[3] = 1; tick(); start[3] = 0;
        repeat (7) tick();
        load = 1; sel = 3; period = 2; tick(); load = 0;
        @(negedge clk);
        chk("t5_time3", o_time[3*W +: W], 8);
        chk("t5_end3_low", o_end[3], 0);
        tick();
        @(negedge clk);
        chk("t5_end3", o_end[3], 1);
        tick();

`ifdef MULTI_TIMER_IRQ_EN
        irq_clr = '1; tick(); irq_clr = '0;
        @(negedge clk);
        chk("irq_cleared", o_irq, 0);
        start[0] = 1; tick(); start[0] = 0;
        repeat (6) tick();
        @(negedge clk);
        chk("irq_end0", o_end[0], 1);
        chk("irq_not_yet", o_irq, 0);
        tick();
        repeat (3) begin
            @(negedge clk);
            chk("irq_set", o_irq, 1);
            tick();
        end
        irq_clr[0] = 1; tick(); irq_clr[0] = 0;
        @(negedge clk);
        chk("irq_clr", o_irq, 0);
        start[0] = 1; tick(); start[0] = 0;
        repeat (6) tick();
        irq_clr[0] = 1; tick(); irq_clr[0] = 0;
        @(negedge clk);
        chk("irq_set_wins", o_irq, 1);
        tick();
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < NCH; k++) begin
                start[k]   = ($urandom_range(0, 15) == 0);
                stop[k]    = ($urandom_range(0, 5) == 0);
                clear[k]   = ($urandom_range(0, 39) == 0);
                irq_clr[k] = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 19) == 0) mode[k] = ~mode[k];
            end
            load   = ($urandom_range(0, 9) == 0);
            sel    = 2'($urandom_range(0, 3));
            period = W'($urandom_range(0, 12));
            rst    = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 0; start = '0; stop = '0; clear = '0; load = 0; irq_clr = '0;
        tick();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
